// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of an 8-bit synchronous RAM port.
// MEM stage has priority over IF; every access is split into little-endian byte transfers.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_re_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic [31:0]           if_data_o,
    output logic                  if_done_o,
    input  logic [1:0]            mem_re_i,
    input  logic                  mem_rsign_i,
    input  logic [1:0]            mem_we_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [31:0]           mem_wdata_i,
    output logic [31:0]           mem_data_o,
    output logic                  mem_done_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_wr_o,
    output logic [7:0]            ram_dout_o,
    input  logic [7:0]            ram_din_i
);

    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    state_t      state;
    logic        is_mem;
    logic        rsign;
    logic [2:0]  nbytes;
    logic [2:0]  cnt;
    logic [23:0] rbuf;
    logic [23:0] wbuf;
    logic        mem_wr_req;
    logic        mem_rd_req;
    logic [31:0] rd_word;

    // Size code 01/10/11 maps to 1/2/4 bytes.
    function automatic logic [2:0] size_bytes(input logic [1:0] code);
        case (code)
            2'b01:   return 3'd1;
            2'b10:   return 3'd2;
            2'b11:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    assign mem_wr_req = (mem_we_i != 2'b00);
    assign mem_rd_req = (mem_re_i != 2'b00);
    assign busy_o     = (state == RD) || (state == WR);

    // Final load value: the last lane comes straight from the RAM this cycle.
    always_comb begin
        rd_word = {ram_din_i, rbuf};
        case (nbytes)
            3'd1:    rd_word = {{24{rsign & ram_din_i[7]}}, ram_din_i};
            3'd2:    rd_word = {{16{rsign & ram_din_i[7]}}, ram_din_i, rbuf[7:0]};
            default: rd_word = {ram_din_i, rbuf};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            is_mem     <= 1'b0;
            rsign      <= 1'b0;
            nbytes     <= 3'd0;
            cnt        <= 3'd0;
            rbuf       <= 24'h0;
            wbuf       <= 24'h0;
            if_data_o  <= 32'h0;
            if_done_o  <= 1'b0;
            mem_data_o <= 32'h0;
            mem_done_o <= 1'b0;
            ram_addr_o <= '0;
            ram_wr_o   <= 1'b0;
            ram_dout_o <= 8'h0;
        end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 3'd0;
                    if (mem_wr_req) begin
                        // A store wins over a simultaneous load request.
                        is_mem     <= 1'b1;
                        rsign      <= 1'b0;
                        nbytes     <= size_bytes(mem_we_i);
                        ram_addr_o <= mem_addr_i;
                        ram_wr_o   <= 1'b1;
                        ram_dout_o <= mem_wdata_i[7:0];
                        wbuf       <= mem_wdata_i[31:8];
                        state      <= WR;
                    end else if (mem_rd_req) begin
                        is_mem     <= 1'b1;
                        rsign      <= mem_rsign_i;
                        nbytes     <= size_bytes(mem_re_i);
                        ram_addr_o <= mem_addr_i;
                        state      <= RD;
                    end else if (if_re_i) begin
                        is_mem     <= 1'b0;
                        rsign      <= 1'b0;
                        nbytes     <= 3'd4;
                        ram_addr_o <= if_addr_i;
                        state      <= RD;
                    end
                end
                RD: begin
                    // cnt counts addresses issued; data for address cnt-1 is on ram_din_i now.
                    if (cnt == nbytes) begin
                        if (is_mem) begin
                            mem_data_o <= rd_word;
                            mem_done_o <= 1'b1;
                        end else begin
                            if_data_o <= rd_word;
                            if_done_o <= 1'b1;
                        end
                        state <= FIN;
                    end else begin
                        case (cnt)
                            3'd1:    rbuf[7:0]   <= ram_din_i;
                            3'd2:    rbuf[15:8]  <= ram_din_i;
                            3'd3:    rbuf[23:16] <= ram_din_i;
                            default: ;
                        endcase
                        if (cnt < nbytes - 3'd1) begin
                            ram_addr_o <= ram_addr_o + ADDR_WIDTH'(1);
                        end
                        cnt <= cnt + 3'd1;
                    end
                end
                WR: begin
                    if (cnt == nbytes - 3'd1) begin
                        ram_wr_o   <= 1'b0;
                        mem_done_o <= 1'b1;
                        state      <= FIN;
                    end else begin
                        ram_addr_o <= ram_addr_o + ADDR_WIDTH'(1);
                        ram_dout_o <= wbuf[7:0];
                        wbuf       <= {8'h00, wbuf[23:8]};
                        cnt        <= cnt + 3'd1;
                    end
                end
                // Done pulse cycle; nothing is accepted so a held request is not re-taken.
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
